cipher_frame_loader: RTL and testbench

CIPHER_FRAME_LOADER -- requirements
Module: cipher_frame_loader

---
 rtl/cipher_frame_pkg.sv | 36 +++
 rtl/frame_word_packer.sv | 63 ++++++
 rtl/cipher_frame_loader.sv | 190 +++++++++++++++++++
 tb/tb_cipher_frame_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_frame_pkg.sv
// Shared types and constants for the cipher frame loader: FSM state
// encoding, accepted command bytes, default parameters and LED decode.
package cipher_frame_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_KEY,
    ST_TEXT,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam logic [7:0] CMD_SIMON = 8'h01;
  localparam logic [7:0] CMD_SPECK = 8'h02;

  localparam int unsigned DEF_WORD_W      = 16;
  localparam int unsigned DEF_KEY_WORDS   = 4;
  localparam int unsigned DEF_TEXT_WORDS  = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 100000;

  // LED vector order: {cmd, key, text, wait, out}
  function automatic logic [4:0] state_leds(state_t s);
    logic [4:0] l;
    l = '0;
    unique case (s)
      ST_CMD:  l = 5'b10000;
      ST_KEY:  l = 5'b01000;
      ST_TEXT: l = 5'b00100;
      ST_WAIT: l = 5'b00010;
      ST_OUT:  l = 5'b00001;
      default: l = 5'b10000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/frame_word_packer.sv
// Packs a byte stream into WORDS words of WORD_W bits, LSB byte first,
// word 0 first. Stored data persists across clears; only counters reset.
module frame_word_packer
  import cipher_frame_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned WORDS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    wr_en_i,
  input  logic [7:0]              byte_i,
  output logic                    last_o,
  output logic [WORDS*WORD_W-1:0] data_o
);

  localparam int unsigned BPW = WORD_W / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS - 1);

  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [WORDS*WORD_W-1:0] data_q, data_d;
  int unsigned             off;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    off        = WORD_W * 32'(word_cnt_q) + 8 * 32'(byte_cnt_q);
    last_o     = wr_en_i && (byte_cnt_q == BYTE_LAST) && (word_cnt_q == WORD_LAST);
    if (clear_i) begin
      byte_cnt_d = '0;
      word_cnt_d = '0;
    end else if (wr_en_i) begin
      data_d[off +: 8] = byte_i;
      if (byte_cnt_q == BYTE_LAST) begin
        byte_cnt_d = '0;
        word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + WCW'(1);
      end else begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/cipher_frame_loader.sv
// UART-fed frame loader: command, key and text bytes in, cipher result out.
// Optional inter-byte timeout in KEY/TEXT enabled by CIPHER_FRAME_TIMEOUT_EN.
module cipher_frame_loader
  import cipher_frame_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned KEY_WORDS   = DEF_KEY_WORDS,
  parameter int unsigned TEXT_WORDS  = DEF_TEXT_WORDS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  output logic [7:0]                   mode,
  output logic [KEY_WORDS*WORD_W-1:0]  key_out,
  output logic [TEXT_WORDS*WORD_W-1:0] text_out,
  output logic                         start,
  input  logic                         done,
  input  logic [TEXT_WORDS*WORD_W-1:0] result,
  output logic                         tx_valid,
  output logic [7:0]                   tx_byte,
  input  logic                         tx_ready,
  output logic                         led_cmd,
  output logic                         led_key,
  output logic                         led_text,
  output logic                         led_wait,
  output logic                         led_out,
  output logic                         timeout_err
);

  localparam int unsigned OUT_W     = TEXT_WORDS * WORD_W;
  localparam int unsigned OUT_BYTES = OUT_W / 8;
  localparam int unsigned OCW       = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BYTES - 1);

  if ((WORD_W < 8) || (WORD_W % 8 != 0) || (KEY_WORDS < 1) || (TEXT_WORDS < 1) ||
      (TIMEOUT_CYC < 1)) begin : g_bad_params
    $error("cipher_frame_loader: illegal parameter combination");
  end

  state_t           state_q;
  logic [4:0]       leds_q;
  logic [7:0]       mode_q;
  logic [7:0]       tx_byte_q;
  logic             start_q;
  logic             tx_valid_q;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_shift;
  logic [OCW-1:0]   out_cnt_q;

  logic cmd_ok, pk_clear, key_wr, text_wr, key_last, text_last, to_fire;

  assign cmd_ok    = (state_q == ST_CMD) && rx_valid &&
                     ((rx_byte == CMD_SIMON) || (rx_byte == CMD_SPECK));
  assign key_wr    = (state_q == ST_KEY) && rx_valid;
  assign text_wr   = (state_q == ST_TEXT) && rx_valid;
  assign pk_clear  = cmd_ok || to_fire;
  assign out_shift = out_q >> 8;

  frame_word_packer #(.WORD_W(WORD_W), .WORDS(KEY_WORDS)) u_key_packer (
    .clk     (clk),
    .rst     (reset),
    .clear_i (pk_clear),
    .wr_en_i (key_wr),
    .byte_i  (rx_byte),
    .last_o  (key_last),
    .data_o  (key_out)
  );

  frame_word_packer #(.WORD_W(WORD_W), .WORDS(TEXT_WORDS)) u_text_packer (
    .clk     (clk),
    .rst     (reset),
    .clear_i (pk_clear),
    .wr_en_i (text_wr),
    .byte_i  (rx_byte),
    .last_o  (text_last),
    .data_o  (text_out)
  );

`ifdef CIPHER_FRAME_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC - 1);

  logic [TCW-1:0] to_cnt_q;
  logic           timeout_err_q;
  logic           in_load;

  assign in_load = (state_q == ST_KEY) || (state_q == ST_TEXT);
  // to_cnt_q counts idle cycles already seen; this cycle is the final idle one
  assign to_fire = in_load && !rx_valid && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= to_fire;
      if (!in_load || rx_valid || to_fire) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TCW'(1);
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CMD;
      leds_q     <= state_leds(ST_CMD);
      mode_q     <= '0;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      out_q      <= '0;
      out_cnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ST_CMD: begin
          if (cmd_ok) begin
            mode_q  <= rx_byte;
            state_q <= ST_KEY;
            leds_q  <= state_leds(ST_KEY);
          end
        end
        ST_KEY: begin
          if (to_fire) begin
            state_q <= ST_CMD;
            leds_q  <= state_leds(ST_CMD);
          end else if (key_last) begin
            state_q <= ST_TEXT;
            leds_q  <= state_leds(ST_TEXT);
          end
        end
        ST_TEXT: begin
          if (to_fire) begin
            state_q <= ST_CMD;
            leds_q  <= state_leds(ST_CMD);
          end else if (text_last) begin
            state_q <= ST_WAIT;
            leds_q  <= state_leds(ST_WAIT);
            start_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // a done coincident with our own start pulse belongs to no request
          if (done && !start_q) begin
            out_q      <= result;
            tx_byte_q  <= result[7:0];
            tx_valid_q <= 1'b1;
            out_cnt_q  <= '0;
            state_q    <= ST_OUT;
            leds_q     <= state_leds(ST_OUT);
          end
        end
        ST_OUT: begin
          if (tx_ready) begin
            if (out_cnt_q == OUT_LAST) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_CMD;
              leds_q     <= state_leds(ST_CMD);
            end else begin
              out_q     <= out_shift;
              tx_byte_q <= out_shift[7:0];
              out_cnt_q <= out_cnt_q + OCW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_CMD;
          leds_q  <= state_leds(ST_CMD);
        end
      endcase
    end
  end

  assign mode     = mode_q;
  assign start    = start_q;
  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
  assign {led_cmd, led_key, led_text, led_wait, led_out} = leds_q;

endmodule

// File: tb/tb_cipher_frame_loader.sv
// Self-checking bench for cipher_frame_loader with a byte-stream reference
// model; the timeout scenario adapts to CIPHER_FRAME_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_cipher_frame_loader;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned KEY_WORDS  = 4;
  localparam int unsigned TEXT_WORDS = 2;
  localparam int unsigned TO_CYC     = 50;
  localparam int unsigned KEY_BYTES  = KEY_WORDS * WORD_W / 8;
  localparam int unsigned TEXT_BYTES = TEXT_WORDS * WORD_W / 8;

  localparam logic [4:0] L_CMD  = 5'b10000;
  localparam logic [4:0] L_TEXT = 5'b00100;
  localparam logic [4:0] L_WAIT = 5'b00010;
  localparam logic [4:0] L_OUT  = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [7:0]  mode;
  logic [63:0] key_out;
  logic [31:0] text_out;
  logic        start;
  logic        done;
  logic [31:0] result;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        led_cmd, led_key, led_text, led_wait, led_out;
  logic        timeout_err;
  logic [4:0]  leds;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;

  assign leds = {led_cmd, led_key, led_text, led_wait, led_out};

  cipher_frame_loader #(
    .WORD_W      (WORD_W),
    .KEY_WORDS   (KEY_WORDS),
    .TEXT_WORDS  (TEXT_WORDS),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .mode        (mode),
    .key_out     (key_out),
    .text_out    (text_out),
    .start       (start),
    .done        (done),
    .result      (result),
    .tx_valid    (tx_valid),
    .tx_byte     (tx_byte),
    .tx_ready    (tx_ready),
    .led_cmd     (led_cmd),
    .led_key     (led_key),
    .led_text    (led_text),
    .led_wait    (led_wait),
    .led_out     (led_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] m, input logic [63:0] k,
                            input logic [31:0] t, input int maxgap);
    send_byte(m);
    for (int i = 0; i < int'(KEY_BYTES); i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(k[8*i +: 8]);
    end
    for (int i = 0; i < int'(TEXT_BYTES); i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(t[8*i +: 8]);
    end
  endtask

  // Accepts result bytes, stalling each one, and records what was seen.
  task automatic collect_out(input int smin, input int smax, output logic [31:0] got,
                             output int ngot, output bit stable_ok, output bit timed_out);
    logic [7:0] b;
    int w;
    int stall;
    got = '0; ngot = 0; stable_ok = 1'b1; timed_out = 1'b0;
    for (int i = 0; i < int'(TEXT_BYTES); i++) begin
      stall = $urandom_range(smin, smax);
      tx_ready = (smax == 0);
      w = 0;
      while (tx_valid !== 1'b1 && w < 50) begin tick(); w++; end
      if (tx_valid !== 1'b1) begin timed_out = 1'b1; break; end
      b = tx_byte;
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        rx_valid = $urandom_range(0, 1);
        rx_byte  = 8'($urandom);
        tick();
        rx_valid = 1'b0;
        if (tx_valid !== 1'b1 || tx_byte !== b) stable_ok = 1'b0;
      end
      tx_ready = 1'b1;
      tick();
      got[8*i +: 8] = b;
      ngot++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; done = 1'b0; result = '0; tx_ready = 1'b0;
    idle(3);
    checks++; if (leds !== L_CMD) begin failures++; $display("FAIL reset_leds got=%b exp=%b", leds, L_CMD); end
    checks++; if ({mode, key_out, text_out} !== '0) begin failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", mode, key_out, text_out); end
    checks++; if ({start, tx_valid, tx_byte, timeout_err} !== '0) begin failures++;
      $display("FAIL reset_ctrl got=%b%b%h%b exp=0", start, tx_valid, tx_byte, timeout_err); end
    reset = 1'b0;
    tick();
    send_byte(8'h7F);
    idle(1);
    checks++; if (leds !== L_CMD || mode !== 8'h00) begin failures++;
      $display("FAIL bad_cmd got leds=%b mode=%h exp leds=%b mode=00", leds, mode, L_CMD); end
  endtask

  task automatic test_vector_frame();
    logic [7:0] vec [13] = '{8'h01, 8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11,
                             8'h18, 8'h19, 8'h65, 8'h65, 8'h77, 8'h68};
    logic [31:0] got; int ngot; bit st; bit to;
    int s0;
    s0 = start_cnt;
    foreach (vec[i]) send_byte(vec[i]);
    checks++; if (leds !== L_WAIT || start !== 1'b1) begin failures++;
      $display("FAIL vec_wait got leds=%b start=%b exp %b/1", leds, start, L_WAIT); end
    checks++; if (mode !== 8'h01) begin failures++; $display("FAIL vec_mode got=%h exp=01", mode); end
    checks++; if (key_out !== 64'h1918_1110_0908_0100) begin failures++;
      $display("FAIL vec_key got=%h exp=1918111009080100", key_out); end
    checks++; if (text_out !== 32'h6877_6565) begin failures++;
      $display("FAIL vec_text got=%h exp=68776565", text_out); end
    done = 1'b1; result = 32'hDEAD_BEEF;
    tick();
    done = 1'b0;
    idle(3);
    checks++; if (leds !== L_WAIT || start_cnt - s0 != 1) begin failures++;
      $display("FAIL vec_start_done got leds=%b starts=%0d exp %b/1", leds, start_cnt - s0, L_WAIT); end
    result = 32'hE9BB_C69B; done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (leds !== L_OUT || tx_valid !== 1'b1) begin failures++;
      $display("FAIL vec_out got leds=%b txv=%b exp %b/1", leds, tx_valid, L_OUT); end
    collect_out(0, 0, got, ngot, st, to);
    checks++; if (got !== 32'hE9BB_C69B || ngot != 4 || to) begin failures++;
      $display("FAIL vec_tx got=%h n=%0d exp=e9bbc69b n=4", got, ngot); end
    checks++; if (leds !== L_CMD || tx_valid !== 1'b0) begin failures++;
      $display("FAIL vec_end got leds=%b txv=%b exp %b/0", leds, tx_valid, L_CMD); end
  endtask

  task automatic test_stall();
    logic [63:0] k; logic [31:0] t, r, got; int ngot; bit st; bit to;
    k = {$urandom, $urandom}; t = $urandom; r = $urandom;
    send_frame(8'h02, k, t, 2);
    idle(1);
    result = r; done = 1'b1; tick(); done = 1'b0;
    collect_out(5, 5, got, ngot, st, to);
    checks++; if (got !== r || ngot != 4 || to) begin failures++;
      $display("FAIL stall_tx got=%h n=%0d exp=%h n=4", got, ngot, r); end
    checks++; if (!st) begin failures++; $display("FAIL stall_hold got=unstable exp=stable"); end
    checks++; if (leds !== L_CMD || tx_valid !== 1'b0) begin failures++;
      $display("FAIL stall_end got leds=%b txv=%b exp %b/0", leds, tx_valid, L_CMD); end
  endtask

  task automatic test_random_frames();
    logic [63:0] k; logic [31:0] t, r, got; logic [7:0] m, junk; int ngot; bit st; bit to;
    int s0;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'h01 || junk == 8'h02) junk = 8'hA5;
        send_byte(junk);
      end
      m = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
      k = {$urandom, $urandom}; t = $urandom; r = $urandom;
      s0 = start_cnt;
      send_frame(m, k, t, 6);
      for (int j = 0; j < 3; j++) send_byte(8'($urandom));
      checks++; if (leds !== L_WAIT || mode !== m || key_out !== k || text_out !== t) begin failures++;
        $display("FAIL rnd_load[%0d] got %b %h %h %h exp %b %h %h %h", it, leds, mode, key_out,
                 text_out, L_WAIT, m, k, t); end
      result = r; done = 1'b1; tick(); done = 1'b0;
      collect_out(0, 3, got, ngot, st, to);
      checks++; if (got !== r || ngot != 4 || !st || to) begin failures++;
        $display("FAIL rnd_tx[%0d] got=%h n=%0d exp=%h n=4", it, got, ngot, r); end
      checks++; if (leds !== L_CMD || key_out !== k || text_out !== t || start_cnt - s0 != 1) begin
        failures++; $display("FAIL rnd_hold[%0d] got %b %h %h starts=%0d exp %b %h %h 1", it, leds,
                             key_out, text_out, start_cnt - s0, L_CMD, k, t); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] k; logic [31:0] t, got; int ngot; bit st; bit to;
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    #2; reset = 1'b1; #1;
    checks++; if (leds !== L_CMD || key_out !== '0 || mode !== '0) begin failures++;
      $display("FAIL rst_mid got leds=%b key=%h mode=%h exp %b 0 0", leds, key_out, mode, L_CMD); end
    tick(); reset = 1'b0; tick();
    k = {$urandom, $urandom}; t = $urandom;
    send_frame(8'h01, k, t, 1);
    checks++; if (key_out !== k || text_out !== t || leds !== L_WAIT) begin failures++;
      $display("FAIL rst_newframe got %h %h %b exp %h %h %b", key_out, text_out, leds, k, t, L_WAIT); end
    idle(1);
    result = 32'h0403_0201; done = 1'b1; tick(); done = 1'b0;
    idle(2);
    #2; reset = 1'b1; #1;
    checks++; if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || leds !== L_CMD) begin failures++;
      $display("FAIL rst_out got txv=%b txb=%h leds=%b exp 0 00 %b", tx_valid, tx_byte, leds, L_CMD); end
    tick(); reset = 1'b0; tick();
    send_frame(8'h02, k, t, 0);
    idle(1);
    result = 32'h1357_9BDF; done = 1'b1; tick(); done = 1'b0;
    collect_out(0, 2, got, ngot, st, to);
    checks++; if (got !== 32'h1357_9BDF || ngot != 4 || to) begin failures++;
      $display("FAIL rst_after_out got=%h n=%0d exp=13579bdf n=4", got, ngot); end
  endtask

  task automatic test_timeout();
    logic [63:0] k; logic [31:0] t, got; int ngot; bit st; bit to;
    int n; bit seen;
    k = {$urandom, $urandom}; t = $urandom;
    send_byte(8'h01);
    for (int i = 0; i < int'(KEY_BYTES); i++) send_byte(k[8*i +: 8]);
    send_byte(t[7:0]);
    send_byte(t[15:8]);
`ifdef CIPHER_FRAME_TIMEOUT_EN
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      tick(); n++;
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || n != int'(TO_CYC)) begin failures++;
      $display("FAIL to_cycle got=%0d exp=%0d", seen ? n : -1, TO_CYC); end
    checks++; if (leds !== L_CMD) begin failures++; $display("FAIL to_state got=%b exp=%b", leds, L_CMD); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse got=1 exp=0"); end
    t = $urandom;
    send_frame(8'h02, k, t, 3);
    checks++; if (text_out !== t || key_out !== k || leds !== L_WAIT) begin failures++;
      $display("FAIL to_reload got %h %h %b exp %h %h %b", key_out, text_out, leds, k, t, L_WAIT); end
`else
    seen = 1'b0;
    for (n = 0; n < int'(TO_CYC) + 20; n++) begin
      tick();
      if (timeout_err !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen || leds !== L_TEXT) begin failures++;
      $display("FAIL no_to got err=%b leds=%b exp 0 %b", seen, leds, L_TEXT); end
    send_byte(t[23:16]);
    send_byte(t[31:24]);
    checks++; if (text_out !== t || leds !== L_WAIT) begin failures++;
      $display("FAIL no_to_finish got %h %b exp %h %b", text_out, leds, t, L_WAIT); end
`endif
    idle(1);
    result = 32'h55AA_33CC; done = 1'b1; tick(); done = 1'b0;
    collect_out(0, 1, got, ngot, st, to);
    checks++; if (got !== 32'h55AA_33CC || ngot != 4 || leds !== L_CMD) begin failures++;
      $display("FAIL to_tx got=%h n=%0d leds=%b exp=55aa33cc 4 %b", got, ngot, leds, L_CMD); end
  endtask

  initial begin
    test_reset();
    test_vector_frame();
    test_stall();
    test_random_frames();
    test_reset_mid_frame();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
